array_arb2: RTL and testbench
=============================

# array_arb2

Two-client arbiter for the Array memory interface. It lets two compiled function blocks, or one function block and a bench/loader, share a single downstream `array` memory instance. It sits directly upstream of `array`: it takes Array-interface requests from two clients, issues one transaction at a time to the memory, and steers the response back to the requester.

## Interface

Parameters:
- `INT_N`, default 8 (`intN`): data width.
- `ADDR_N`, default 8 (`addrN`): address width.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `a_addr`  in  ADDR_N  client A address.
- `a_we`  in  1  client A write enable.
- `a_di`  in  INT_N  client A write data.
- `a_valid`  in  1  client A request valid.
- `a_do`  out  INT_N  client A read data.
- `a_ready`  out  1  client A transaction complete.
- `b_addr`, `b_we`, `b_di`, `b_valid`, `b_do`, `b_ready`: same as client A, for client B.
- `m_addr`  out  ADDR_N  address to `array`.
- `m_we`  out  1  write enable to `array`.
- `m_di`  out  INT_N  write data to `array`.
- `m_valid`  out  1  request valid to `array`.
- `m_do`  in  INT_N  read data from `array`.
- `m_ready`  in  1  completion pulse from `array`.

## Operation

Protocol:
- A client holds `addr`/`we`/`di` stable with `valid` high until it samples `ready` high.
- It drops `valid` on that same edge. `valid` still high on the following cycle is a new request.

FSM states: `IDLE`, `BUSY_A`, `BUSY_B`. Reset state is `IDLE`.

In `IDLE`:
- If neither client is valid, stay in `IDLE`.
- If exactly one client is valid, grant it.
- If both are valid, resolve per Configuration.
- On grant, register the winner's `addr`/`we`/`di` into `m_addr`/`m_we`/`m_di`, set `m_valid`=1, go to `BUSY_x`, and update `last_grant`.

In `BUSY_x`:
- `m_*` are held stable. All other requests wait; they are not granted.
- On `m_ready`=1: `x_ready`=`m_ready` (combinational), `x_do`=`m_do`. Next state is `IDLE` with `m_valid`=0.

Output and signal rules:
- The non-granted client's `ready`=0 and `do`=0 at all times.
- `m_ready` seen while in `IDLE` is ignored.
- Widths are passed through; no arithmetic is performed.

Reset:
- All outputs are 0: `m_addr`, `m_we`, `m_di`, `m_valid`, `a_ready`, `b_ready`, `a_do`, `b_do`.
- `last_grant` resets to B.
- `rst` during `BUSY_x` aborts the transaction: `m_valid`=0 on the next cycle and no `ready` is given to the client. A request still held after `rst` is re-arbitrated.

## Timing

- Grant latency: `x_valid` high in `IDLE` at cycle 0 → `m_valid`=1 with registered request from cycle 1.
- Completion: `x_ready` is asserted in the same cycle as `m_ready`. Minimum total is 1 cycle from grant to `x_ready`, if `array` responds in cycle 1.
- Turnaround: 1 cycle in `IDLE` between transactions. Back-to-back throughput is therefore at most one transaction per 2 cycles plus memory latency.
- `m_valid` is registered. `x_ready` and `x_do` are combinational from `m_ready`/`m_do` and the grant state.

## Configuration

Macro: `ARRAY_ARB_RR_EN`.
- Defined: on a tie, grant the client not equal to `last_grant` (round-robin). The first tie after reset goes to A.
- Undefined: on a tie, A always wins (fixed priority). `last_grant` is not needed and may be removed.

## Test plan

- Reset: hold `rst` 2 cycles with both clients valid → all outputs 0 and no grant while `rst`=1.
- Write: A writes addr=3, di=42, `we`=1 at cycle 0; `array` answers at cycle 1 → `m_addr`=3, `m_we`=1, `m_di`=42, `m_valid`=1 at cycle 1; `a_ready` pulses at cycle 1; `b_ready` stays 0; `m_valid`=0 at cycle 2.
- Read back: B reads addr=3 after the write → `b_do`=42 while `b_ready`=1; `a_do`=0.
- Tie: A and B both valid every cycle for 4 transactions → order A,B,A,B with `ARRAY_ARB_RR_EN` defined; A,A,A,A without it.
- Slow memory: `m_ready` delayed 5 cycles with B valid during `BUSY_A` → `m_*` stable all 5 cycles; B is granted only after `IDLE`.
- Abort: `rst` pulsed while in `BUSY_B` → `m_valid`=0 next cycle, no `b_ready`; B still valid is re-granted 1 cycle after `rst` drops.

Source files
------------

// File: rtl/array_arb2.sv
// Two-client arbiter sharing one downstream array memory; one transaction in flight at a time.
// Define ARRAY_ARB_RR_EN for round-robin tie-breaking; otherwise client A wins every tie.
module array_arb2 #(
    parameter int INT_N  = 8,
    parameter int ADDR_N = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_N-1:0] a_addr,
    input  logic              a_we,
    input  logic [INT_N-1:0]  a_di,
    input  logic              a_valid,
    output logic [INT_N-1:0]  a_do,
    output logic              a_ready,
    input  logic [ADDR_N-1:0] b_addr,
    input  logic              b_we,
    input  logic [INT_N-1:0]  b_di,
    input  logic              b_valid,
    output logic [INT_N-1:0]  b_do,
    output logic              b_ready,
    output logic [ADDR_N-1:0] m_addr,
    output logic              m_we,
    output logic [INT_N-1:0]  m_di,
    output logic              m_valid,
    input  logic [INT_N-1:0]  m_do,
    input  logic              m_ready
);

    typedef enum logic [1:0] {IDLE, BUSY_A, BUSY_B} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_N-1:0] m_addr_reg, m_addr_next;
    logic              m_we_reg, m_we_next;
    logic [INT_N-1:0]  m_di_reg, m_di_next;
    logic              m_valid_reg, m_valid_next;
    logic              grant_a, grant_b;
    logic              prefer_a;

`ifdef ARRAY_ARB_RR_EN
    // last_b_reg is 1 when B held the most recent grant; a tie then goes to A.
    logic last_b_reg, last_b_next;
    assign prefer_a = last_b_reg;
`else
    assign prefer_a = 1'b1;
`endif

    always_comb begin
        state_next   = state_reg;
        m_addr_next  = m_addr_reg;
        m_we_next    = m_we_reg;
        m_di_next    = m_di_reg;
        m_valid_next = m_valid_reg;
        grant_a      = 1'b0;
        grant_b      = 1'b0;
`ifdef ARRAY_ARB_RR_EN
        last_b_next  = last_b_reg;
`endif
        case (state_reg)
            IDLE: begin
                grant_a = a_valid && (!b_valid || prefer_a);
                grant_b = b_valid && !grant_a;
                if (grant_a) begin
                    m_addr_next  = a_addr;
                    m_we_next    = a_we;
                    m_di_next    = a_di;
                    m_valid_next = 1'b1;
                    state_next   = BUSY_A;
`ifdef ARRAY_ARB_RR_EN
                    last_b_next  = 1'b0;
`endif
                end else if (grant_b) begin
                    m_addr_next  = b_addr;
                    m_we_next    = b_we;
                    m_di_next    = b_di;
                    m_valid_next = 1'b1;
                    state_next   = BUSY_B;
`ifdef ARRAY_ARB_RR_EN
                    last_b_next  = 1'b1;
`endif
                end
            end
            BUSY_A, BUSY_B: begin
                if (m_ready) begin
                    m_valid_next = 1'b0;
                    state_next   = IDLE;
                end
            end
            default: begin
                m_valid_next = 1'b0;
                state_next   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            m_addr_reg  <= '0;
            m_we_reg    <= 1'b0;
            m_di_reg    <= '0;
            m_valid_reg <= 1'b0;
`ifdef ARRAY_ARB_RR_EN
            last_b_reg  <= 1'b1;
`endif
        end else begin
            state_reg   <= state_next;
            m_addr_reg  <= m_addr_next;
            m_we_reg    <= m_we_next;
            m_di_reg    <= m_di_next;
            m_valid_reg <= m_valid_next;
`ifdef ARRAY_ARB_RR_EN
            last_b_reg  <= last_b_next;
`endif
        end
    end

    assign m_addr  = m_addr_reg;
    assign m_we    = m_we_reg;
    assign m_di    = m_di_reg;
    assign m_valid = m_valid_reg;

    // Response steering: index 0 is client A, index 1 is client B. Reset suppresses a
    // completion that coincides with an aborted transaction.
    logic [1:0]       cl_busy;
    logic [1:0]       cl_ready;
    logic [INT_N-1:0] cl_do [2];

    assign cl_busy = {state_reg == BUSY_B, state_reg == BUSY_A};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            assign cl_ready[gi] = cl_busy[gi] && m_ready && !rst;
            assign cl_do[gi]    = cl_ready[gi] ? m_do : '0;
        end
    endgenerate

    assign a_ready = cl_ready[0];
    assign b_ready = cl_ready[1];
    assign a_do    = cl_do[0];
    assign b_do    = cl_do[1];

endmodule

// File: tb/tb_array_arb2.sv
// Self-checking bench for array_arb2: directed vector table, corner sequences and a
// randomized run against a transaction-level reference model.
module tb_array_arb2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_addr, a_di, a_do, b_addr, b_di, b_do;
    logic       a_we, a_valid, a_ready, b_we, b_valid, b_ready;
    logic [7:0] m_addr, m_di, m_do;
    logic       m_we, m_valid, m_ready;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] mem [256];

    array_arb2 #(.INT_N(8), .ADDR_N(8)) dut (
        .clk(clk), .rst(rst),
        .a_addr(a_addr), .a_we(a_we), .a_di(a_di), .a_valid(a_valid),
        .a_do(a_do), .a_ready(a_ready),
        .b_addr(b_addr), .b_we(b_we), .b_di(b_di), .b_valid(b_valid),
        .b_do(b_do), .b_ready(b_ready),
        .m_addr(m_addr), .m_we(m_we), .m_di(m_di), .m_valid(m_valid),
        .m_do(m_do), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         cl;      // 0 = A, 1 = B
        bit         we;
        logic [7:0] addr;
        logic [7:0] di;
        int         lat;     // idle memory cycles before m_ready
        logic [7:0] exp_do;  // read result expected by the client
    } vec_t;

    vec_t vt [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_txn(input int idx, input vec_t v);
        string p;
        p = $sformatf("vec%0d", idx);
        if (v.cl == 1'b0) begin
            a_addr = v.addr; a_we = v.we; a_di = v.di; a_valid = 1'b1;
        end else begin
            b_addr = v.addr; b_we = v.we; b_di = v.di; b_valid = 1'b1;
        end
        m_ready = 1'b0;
        step();
        chk({p, "_grant_mvalid"}, 32'(m_valid), 32'd1);
        chk({p, "_maddr"}, 32'(m_addr), 32'(v.addr));
        chk({p, "_mwe"}, 32'(m_we), 32'(v.we));
        chk({p, "_mdi"}, 32'(m_di), 32'(v.di));
        for (int k = 0; k < v.lat; k++) begin
            chk({p, "_early_ready"}, 32'(v.cl ? b_ready : a_ready), 32'd0);
            step();
            chk({p, "_hold_maddr"}, 32'(m_addr), 32'(v.addr));
        end
        m_ready = 1'b1;
        m_do = v.we ? 8'($urandom) : mem[v.addr];
        #1;
        chk({p, "_ready"}, 32'(v.cl ? b_ready : a_ready), 32'd1);
        chk({p, "_other_ready"}, 32'(v.cl ? a_ready : b_ready), 32'd0);
        chk({p, "_other_do"}, 32'(v.cl ? a_do : b_do), 32'd0);
        if (!v.we) chk({p, "_rdata"}, 32'(v.cl ? b_do : a_do), 32'(v.exp_do));
        if (v.we) mem[v.addr] = v.di;
        $display("txn %s client=%s we=%0d addr=%0d di=%0d do=%0d", p, v.cl ? "B" : "A",
                 v.we, v.addr, v.di, v.cl ? b_do : a_do);
        step();
        a_valid = 1'b0; b_valid = 1'b0; m_ready = 1'b0;
        #1;
        chk({p, "_after_mvalid"}, 32'(m_valid), 32'd0);
    endtask

    // Random-phase reference model state
    int         owner;     // 0 none, 1 A, 2 B
    bit         last_b;
    int         wait_n;
    bit         a_pend, b_pend;
    logic [7:0] ar_addr, ar_di, br_addr, br_di;
    bit         ar_we, br_we;
    logic [7:0] e_addr, e_di;
    bit         e_we;
    bit         exp_ar, exp_br, pick_a;
    bit         tie_b [4];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        vt[0] = '{cl: 1'b0, we: 1'b1, addr: 8'd3, di: 8'd42, lat: 0, exp_do: 8'd0};
        vt[1] = '{cl: 1'b1, we: 1'b0, addr: 8'd3, di: 8'd0,  lat: 0, exp_do: 8'd42};
        vt[2] = '{cl: 1'b1, we: 1'b1, addr: 8'd7, di: 8'd99, lat: 2, exp_do: 8'd0};
        vt[3] = '{cl: 1'b0, we: 1'b0, addr: 8'd7, di: 8'd0,  lat: 1, exp_do: 8'd99};
        vt[4] = '{cl: 1'b0, we: 1'b1, addr: 8'd3, di: 8'd17, lat: 3, exp_do: 8'd0};
        vt[5] = '{cl: 1'b1, we: 1'b0, addr: 8'd3, di: 8'd0,  lat: 0, exp_do: 8'd17};
`ifdef ARRAY_ARB_RR_EN
        tie_b = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        tie_b = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

        // Reset held two cycles with both clients requesting and a stray m_ready
        rst = 1'b1;
        a_addr = 8'd1; a_we = 1'b1; a_di = 8'h11; a_valid = 1'b1;
        b_addr = 8'd2; b_we = 1'b1; b_di = 8'h22; b_valid = 1'b1;
        m_ready = 1'b1; m_do = 8'hff;
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rst_mvalid", 32'(m_valid), 32'd0);
            chk("rst_maddr", 32'(m_addr), 32'd0);
            chk("rst_mwe", 32'(m_we), 32'd0);
            chk("rst_mdi", 32'(m_di), 32'd0);
            chk("rst_ready", {30'd0, a_ready, b_ready}, 32'd0);
            chk("rst_do", {16'd0, a_do, b_do}, 32'd0);
        end
        a_valid = 1'b0; b_valid = 1'b0; m_ready = 1'b0; rst = 1'b0;
        step();
        chk("idle_mvalid", 32'(m_valid), 32'd0);

        for (int i = 0; i < 6; i++) do_txn(i, vt[i]);

        // Tie: both clients keep requesting for four transactions
        a_addr = 8'd10; a_we = 1'b0; a_di = 8'd0; a_valid = 1'b1;
        b_addr = 8'd20; b_we = 1'b0; b_di = 8'd0; b_valid = 1'b1;
        m_ready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            step();
            chk("tie_mvalid", 32'(m_valid), 32'd1);
            chk($sformatf("tie%0d_winner_addr", t), 32'(m_addr), tie_b[t] ? 32'd20 : 32'd10);
            m_ready = 1'b1; m_do = 8'(t + 1);
            #1;
            chk($sformatf("tie%0d_ready", t), {30'd0, a_ready, b_ready},
                tie_b[t] ? 32'd1 : 32'd2);
            $display("txn tie%0d winner=%s", t, b_ready ? "B" : "A");
            step();
            m_ready = 1'b0;
            #1;
            chk("tie_turnaround", 32'(m_valid), 32'd0);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        step();

        // Slow memory with B waiting during BUSY_A
        a_addr = 8'd5; a_we = 1'b1; a_di = 8'h5a; a_valid = 1'b1;
        step();
        b_addr = 8'd6; b_we = 1'b0; b_di = 8'd0; b_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("slow_mvalid", 32'(m_valid), 32'd1);
            chk("slow_maddr", 32'(m_addr), 32'd5);
            chk("slow_mwe", 32'(m_we), 32'd1);
            chk("slow_mdi", 32'(m_di), 32'h5a);
            chk("slow_b_ready", 32'(b_ready), 32'd0);
            step();
        end
        m_ready = 1'b1; m_do = 8'd0;
        #1;
        chk("slow_a_ready", {30'd0, a_ready, b_ready}, 32'd2);
        mem[5] = 8'h5a;
        $display("txn slow client=A addr=5 we=1");
        step();
        a_valid = 1'b0; m_ready = 1'b0;
        #1;
        chk("slow_idle_gap", 32'(m_valid), 32'd0);
        step();
        chk("slow_b_grant", 32'(m_valid), 32'd1);
        chk("slow_b_addr", 32'(m_addr), 32'd6);
        m_ready = 1'b1; m_do = mem[6];
        #1;
        chk("slow_b_ready_done", 32'(b_ready), 32'd1);
        $display("txn slow client=B addr=6 we=0");
        step();
        b_valid = 1'b0; m_ready = 1'b0;

        // Abort: reset while B is being served
        b_addr = 8'd9; b_we = 1'b0; b_di = 8'd0; b_valid = 1'b1;
        step();
        chk("abort_grant", 32'(m_valid), 32'd1);
        rst = 1'b1; m_ready = 1'b1; m_do = 8'h77;
        #1;
        chk("abort_no_ready", 32'(b_ready), 32'd0);
        chk("abort_no_do", 32'(b_do), 32'd0);
        step();
        rst = 1'b0; m_ready = 1'b0;
        #1;
        chk("abort_mvalid", 32'(m_valid), 32'd0);
        step();
        chk("abort_regrant", 32'(m_valid), 32'd1);
        chk("abort_regrant_addr", 32'(m_addr), 32'd9);
        m_ready = 1'b1; m_do = mem[9];
        #1;
        chk("abort_done_ready", 32'(b_ready), 32'd1);
        $display("txn abort client=B addr=9 regranted");
        step();
        b_valid = 1'b0; m_ready = 1'b0;

        // Randomized run against the transaction-level model
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        owner = 0; last_b = 1'b1; wait_n = 0; a_pend = 1'b0; b_pend = 1'b0;
        e_addr = 8'd0; e_di = 8'd0; e_we = 1'b0;
        ar_addr = 8'd0; ar_di = 8'd0; ar_we = 1'b0;
        br_addr = 8'd0; br_di = 8'd0; br_we = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!a_pend && $urandom_range(0, 2) == 0) begin
                a_pend = 1'b1; ar_addr = 8'($urandom_range(0, 15));
                ar_we = 1'($urandom_range(0, 1)); ar_di = 8'($urandom);
            end
            if (!b_pend && $urandom_range(0, 2) == 0) begin
                b_pend = 1'b1; br_addr = 8'($urandom_range(0, 15));
                br_we = 1'($urandom_range(0, 1)); br_di = 8'($urandom);
            end
            a_valid = a_pend; a_addr = ar_addr; a_we = ar_we; a_di = ar_di;
            b_valid = b_pend; b_addr = br_addr; b_we = br_we; b_di = br_di;
            if (owner != 0) m_ready = (wait_n == 0);
            else            m_ready = ($urandom_range(0, 7) == 0);
            m_do = (owner != 0 && m_ready) ? mem[e_addr] : 8'($urandom);
            #1;
            chk("rnd_mvalid", 32'(m_valid), (owner != 0) ? 32'd1 : 32'd0);
            if (owner != 0) begin
                chk("rnd_mreq", {15'd0, m_we, m_addr, m_di}, {15'd0, e_we, e_addr, e_di});
            end
            exp_ar = (owner == 1) && m_ready;
            exp_br = (owner == 2) && m_ready;
            chk("rnd_ready", {30'd0, a_ready, b_ready}, {30'd0, exp_ar, exp_br});
            if (exp_ar) chk("rnd_a_do", 32'(a_do), 32'(m_do));
            else if (owner != 1) chk("rnd_a_do_zero", 32'(a_do), 32'd0);
            if (exp_br) chk("rnd_b_do", 32'(b_do), 32'(m_do));
            else if (owner != 2) chk("rnd_b_do_zero", 32'(b_do), 32'd0);

            if (owner != 0) begin
                if (m_ready) begin
                    $display("txn rnd client=%s we=%0d addr=%0d di=%0d do=%0d",
                             owner == 1 ? "A" : "B", e_we, e_addr, e_di, m_do);
                    if (e_we) mem[e_addr] = e_di;
                    if (owner == 1) a_pend = 1'b0;
                    else            b_pend = 1'b0;
                    owner = 0;
                end else begin
                    wait_n--;
                end
            end else if (a_pend || b_pend) begin
`ifdef ARRAY_ARB_RR_EN
                pick_a = a_pend && (!b_pend || last_b);
`else
                pick_a = a_pend;
`endif
                owner  = pick_a ? 1 : 2;
                last_b = !pick_a;
                e_addr = pick_a ? ar_addr : br_addr;
                e_we   = pick_a ? ar_we : br_we;
                e_di   = pick_a ? ar_di : br_di;
                wait_n = $urandom_range(0, 3);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
